// File: rtl/sisc_pkg.sv
// Shared SISC definitions: datapath widths and the fetch sequencer state encoding.
package sisc_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 32;
    localparam int ENTRY_W = ADDR_W + INSTR_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH-entry synchronous FIFO with flush, occupancy count
// and a combinational head read at the read pointer.
module fetch_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 48,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clk,
    input  logic             rst_f,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] head_o,
    output logic             valid_o,
    output logic             full_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_eff, pop_eff;

    assign valid_o  = (count_q != '0);
    assign full_o   = (count_q == CW'(DEPTH));
    assign pop_eff  = pop_i && valid_o;
    // A push into a full queue is only legal when the head leaves the same cycle.
    assign push_eff = push_i && (!full_o || pop_eff);
    assign head_o   = mem_q[rd_ptr_q];
    assign count_o  = count_q;

    // Pointer and occupancy next-state; flush overrides everything.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_eff) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_eff)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push_eff && !pop_eff)      count_d = count_q + CW'(1);
            else if (pop_eff && !push_eff) count_d = count_q - CW'(1);
        end
    end

    // Pointer/count registers.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; cleared on reset so the head reads zero until first fill.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push_eff && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, drives the IM address,
// queues {pc, instr} pairs and hands the head to decode. Handles redirect
// (flush + refetch), fetch pause and permanent halt.
module fetch_ctrl
    import sisc_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic                     clk,
    input  logic                     rst_f,
    input  logic                     fetch_en,
    output logic [ADDR_W-1:0]        im_addr,
    input  logic [INSTR_W-1:0]       im_data,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [INSTR_W-1:0]       instr_data,
    output logic [ADDR_W-1:0]        instr_pc,
    input  logic                     redirect_en,
    input  logic [ADDR_W-1:0]        redirect_addr,
    input  logic                     halt_req,
    output logic                     halted,
    output logic [$clog2(DEPTH):0]   fq_count
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              push, pop, flush, full;
    logic [ENTRY_W-1:0] head;

    assign pop   = instr_valid && instr_ready;
    // Halt beats redirect; HALTED ignores redirects entirely.
    assign flush = redirect_en && !halt_req && (state_q != HALTED);
    // fetch_en gates the push directly so a mid-stream pause takes effect
    // in the same cycle rather than one cycle later via the state change.
    assign push  = (state_q == FETCH) && fetch_en && !redirect_en && !halt_req
                   && (!full || pop);

    assign im_addr    = pc_q;
    assign instr_pc   = head[ENTRY_W-1:INSTR_W];
    assign instr_data = head[INSTR_W-1:0];
    assign halted     = (state_q == HALTED);

    // Next state and next fetch PC.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE:    if (fetch_en)  state_d = FETCH;
            FETCH:   if (!fetch_en) state_d = IDLE;
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
        endcase
        if (halt_req && state_q != HALTED) state_d = HALTED;
        if (flush)     pc_d = redirect_addr;
        else if (push) pc_d = pc_q + ADDR_W'(1);
    end

    // State and PC registers.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_f   (rst_f),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i ({pc_q, im_data}),
        .head_o  (head),
        .valid_o (instr_valid),
        .full_o  (full),
        .count_o (fq_count)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: IM model is mem[a] = A000_0000 + a;
// expected {pc,data} pairs are queued as stimulus is set up and checked on
// every accepted head.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_f = 1'b0;
    logic        fetch_en = 1'b0;
    logic [15:0] im_addr;
    logic [31:0] im_data;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_data;
    logic [15:0] instr_pc;
    logic        redirect_en = 1'b0;
    logic [15:0] redirect_addr = 16'h0;
    logic        halt_req = 1'b0;
    logic        halted;
    logic [2:0]  fq_count;

    int          checks = 0;
    int          errors = 0;
    int          npop = 0;
    logic [47:0] exp_q[$];

    always #5 clk = ~clk;

    assign im_data = 32'hA000_0000 + {16'h0, im_addr};

    fetch_ctrl #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clk           (clk),
        .rst_f         (rst_f),
        .fetch_en      (fetch_en),
        .im_addr       (im_addr),
        .im_data       (im_data),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_data    (instr_data),
        .instr_pc      (instr_pc),
        .redirect_en   (redirect_en),
        .redirect_addr (redirect_addr),
        .halt_req      (halt_req),
        .halted        (halted),
        .fq_count      (fq_count)
    );

    // One cycle: scoreboard the head at mid-cycle, return just after the next edge.
    task automatic step(int n = 1);
        logic [47:0] e;
        repeat (n) begin
            @(negedge clk);
            if (rst_f && instr_valid && instr_ready) begin
                npop++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected got pc=%h data=%h", instr_pc, instr_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({instr_pc, instr_data} !== e) begin
                        errors++;
                        $display("FAIL sb_head got %h_%h exp %h_%h", instr_pc, instr_data, e[47:32], e[31:0]);
                    end
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(logic [15:0] pc0, int n);
        logic [15:0] p;
        for (int i = 0; i < n; i++) begin
            p = pc0 + 16'(i);
            exp_q.push_back({p, 32'hA000_0000 + {16'h0, p}});
        end
    endtask

    task automatic wait_pops(int target, int budget, output bit ok, output int steps);
        ok = 1'b0;
        steps = 0;
        for (int i = 0; i < budget; i++) begin
            if (npop >= target) break;
            step();
            steps++;
        end
        ok = (npop >= target);
    endtask

    task automatic apply_reset();
        rst_f = 1'b0; fetch_en = 1'b0; instr_ready = 1'b0;
        redirect_en = 1'b0; halt_req = 1'b0; redirect_addr = 16'h0;
        exp_q.delete();
        npop = 0;
        step(2);
        rst_f = 1'b1;
    endtask

    task automatic test_reset();
        rst_f = 1'b0;
        #3;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
        checks++; if (instr_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", instr_data); end
        checks++; if (instr_pc !== 16'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", instr_pc); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
        checks++; if (fq_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", fq_count); end
        checks++; if (im_addr !== 16'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", im_addr); end
    endtask

    task automatic test_stream();
        bit ok; int steps;
        apply_reset();
        push_exp(16'h0, 8);
        fetch_en = 1'b1; instr_ready = 1'b1;
        step();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stream_lat_early got %b exp 0", instr_valid); end
        step();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0) begin errors++; $display("FAIL stream_lat got v=%b pc=%h exp v=1 pc=0000", instr_valid, instr_pc); end
        wait_pops(8, 20, ok, steps);
        instr_ready = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL stream_timeout got %0d pops exp 8", npop); end
        checks++; if (steps != 8) begin errors++; $display("FAIL stream_rate got %0d cycles exp 8", steps); end
    endtask

    task automatic test_stall();
        bit ok; int steps;
        apply_reset();
        fetch_en = 1'b1; instr_ready = 1'b0;
        step(10);
        checks++; if (fq_count !== 3'd4) begin errors++; $display("FAIL stall_count got %0d exp 4", fq_count); end
        checks++; if (im_addr !== 16'h0004) begin errors++; $display("FAIL stall_addr got %h exp 0004", im_addr); end
        push_exp(16'h0, 6);
        npop = 0;
        instr_ready = 1'b1;
        wait_pops(6, 20, ok, steps);
        instr_ready = 1'b0;
        checks++; if (!ok || steps != 6) begin errors++; $display("FAIL stall_drain got %0d pops in %0d cycles exp 6 in 6", npop, steps); end
    endtask

    task automatic test_redirect();
        bit ok; int steps;
        apply_reset();
        push_exp(16'h0, 5);
        fetch_en = 1'b1; instr_ready = 1'b1;
        wait_pops(5, 30, ok, steps);
        instr_ready = 1'b0;
        for (int i = 0; i < 10 && fq_count != 3'd4; i++) step();
        checks++; if (fq_count !== 3'd4 || instr_pc !== 16'h0005) begin errors++; $display("FAIL redir_prefill got cnt=%0d pc=%h exp cnt=4 pc=0005", fq_count, instr_pc); end
        redirect_en = 1'b1; redirect_addr = 16'h0100;
        step();
        redirect_en = 1'b0;
        checks++; if (fq_count !== 3'd0 || instr_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got cnt=%0d v=%b exp cnt=0 v=0", fq_count, instr_valid); end
        checks++; if (im_addr !== 16'h0100) begin errors++; $display("FAIL redir_addr got %h exp 0100", im_addr); end
        push_exp(16'h0100, 4);
        npop = 0;
        instr_ready = 1'b1;
        step();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0100) begin errors++; $display("FAIL redir_lat got v=%b pc=%h exp v=1 pc=0100", instr_valid, instr_pc); end
        wait_pops(4, 20, ok, steps);
        instr_ready = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL redir_timeout got %0d pops exp 4", npop); end
    endtask

    task automatic test_wrap();
        bit ok; int steps;
        apply_reset();
        redirect_en = 1'b1; redirect_addr = 16'hFFFE;
        step();
        redirect_en = 1'b0;
        step(2);
        checks++; if (im_addr !== 16'hFFFE || instr_valid !== 1'b0) begin errors++; $display("FAIL idle_redir got addr=%h v=%b exp addr=fffe v=0", im_addr, instr_valid); end
        push_exp(16'hFFFE, 4);
        fetch_en = 1'b1; instr_ready = 1'b1;
        wait_pops(4, 20, ok, steps);
        instr_ready = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout got %0d pops exp 4", npop); end
    endtask

    task automatic test_halt();
        apply_reset();
        fetch_en = 1'b1; instr_ready = 1'b0;
        for (int i = 0; i < 10 && fq_count != 3'd3; i++) step();
        checks++; if (fq_count !== 3'd3 || im_addr !== 16'h0003) begin errors++; $display("FAIL halt_prefill got cnt=%0d addr=%h exp cnt=3 addr=0003", fq_count, im_addr); end
        halt_req = 1'b1; redirect_en = 1'b1; redirect_addr = 16'h0200;
        step();
        halt_req = 1'b0; redirect_en = 1'b0;
        checks++; if (halted !== 1'b1 || fq_count !== 3'd3 || im_addr !== 16'h0003) begin errors++; $display("FAIL halt_enter got h=%b cnt=%0d addr=%h exp h=1 cnt=3 addr=0003", halted, fq_count, im_addr); end
        redirect_en = 1'b1; redirect_addr = 16'h0300;
        step();
        redirect_en = 1'b0;
        checks++; if (im_addr !== 16'h0003 || fq_count !== 3'd3) begin errors++; $display("FAIL halt_redir got addr=%h cnt=%0d exp addr=0003 cnt=3", im_addr, fq_count); end
        push_exp(16'h0, 3);
        npop = 0;
        instr_ready = 1'b1;
        step(6);
        instr_ready = 1'b0;
        checks++; if (npop != 3) begin errors++; $display("FAIL halt_drain got %0d pops exp 3", npop); end
        checks++; if (fq_count !== 3'd0 || instr_valid !== 1'b0 || im_addr !== 16'h0003 || halted !== 1'b1) begin errors++; $display("FAIL halt_frozen got cnt=%0d v=%b addr=%h h=%b exp 0 0 0003 1", fq_count, instr_valid, im_addr, halted); end
    endtask

    task automatic test_async_reset();
        bit ok; int steps;
        apply_reset();
        push_exp(16'h0, 3);
        fetch_en = 1'b1; instr_ready = 1'b1;
        wait_pops(3, 20, ok, steps);
        #2 rst_f = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0 || fq_count !== 3'd0) begin errors++; $display("FAIL arst_queue got v=%b cnt=%0d exp 0 0", instr_valid, fq_count); end
        checks++; if (im_addr !== 16'h0 || halted !== 1'b0 || instr_pc !== 16'h0 || instr_data !== 32'h0) begin errors++; $display("FAIL arst_outs got addr=%h h=%b pc=%h d=%h exp zeros", im_addr, halted, instr_pc, instr_data); end
        exp_q.delete();
        npop = 0;
        #2 rst_f = 1'b1;
        push_exp(16'h0, 4);
        wait_pops(4, 20, ok, steps);
        instr_ready = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL arst_restart got %0d pops exp 4", npop); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_wrap();
        test_halt();
        test_async_reset();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d entries exp 0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
